// File: rtl/nanorv32_fetch_buffer.sv
// Instruction prefetch buffer between the nanorv32 code port and a 1-cycle code RAM.
// Optional hit/miss counters are enabled by defining NANORV32_FETCH_BUF_STATS_EN.
module nanorv32_fetch_buffer #(
    parameter int AW       = 15,
    parameter int DEPTH    = 2,
    parameter int DATA_MSB = 31,
    parameter int ADDR_MSB = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_MSB:0] cpu_codemem_addr,
    input  logic              cpu_codemem_req,
    output logic              codemem_cpu_ack,
    output logic [DATA_MSB:0] codemem_cpu_rdata,
    output logic [AW-3:0]     buf_mem_addr,
    output logic              buf_mem_en,
    input  logic [DATA_MSB:0] mem_buf_rdata,
    output logic              dbg_state
`ifdef NANORV32_FETCH_BUF_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);
    // Handshake: the CPU holds req and addr until it sees ack (combinational, same cycle);
    // buf_mem_en is a read strobe whose data appears on mem_buf_rdata one cycle later.

    localparam int TW = AW - 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       fifo_tag_q  [DEPTH];
    logic [TW-1:0]       fifo_tag_d  [DEPTH];
    logic [DATA_MSB:0]   fifo_data_q [DEPTH];
    logic [DATA_MSB:0]   fifo_data_d [DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                inflight_valid_q, inflight_valid_d;
    logic [TW-1:0]       inflight_tag_q, inflight_tag_d;
    logic [TW-1:0]       next_addr_q, next_addr_d;

    logic [TW-1:0]       req_tag;
    logic                fifo_empty;
    logic                head_valid;
    logic [TW-1:0]       head_tag;
    logic [DATA_MSB:0]   head_data;
    logic                hit;
    logic                miss;
    logic                pop_fifo;
    logic                bypass_take;
    logic                push;
    logic                issue;
    logic [CW:0]         level;
    logic                mem_en;
    logic [TW-1:0]       mem_addr;
    logic                unused_addr_bits;

    assign req_tag          = cpu_codemem_addr[AW-1:2];
    assign unused_addr_bits = ^{cpu_codemem_addr[ADDR_MSB:AW], cpu_codemem_addr[1:0]};

    always_comb begin
        state_d          = state_q;
        fifo_tag_d       = fifo_tag_q;
        fifo_data_d      = fifo_data_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        inflight_valid_d = 1'b0;
        inflight_tag_d   = inflight_tag_q;
        next_addr_d      = next_addr_q;
        mem_en           = 1'b0;
        mem_addr         = '0;

        // The returning RAM word acts as the head when the FIFO is empty (bypass).
        fifo_empty = (count_q == '0);
        head_valid = !fifo_empty || inflight_valid_q;
        head_tag   = fifo_empty ? inflight_tag_q : fifo_tag_q[rd_ptr_q];
        head_data  = fifo_empty ? mem_buf_rdata  : fifo_data_q[rd_ptr_q];

        hit         = cpu_codemem_req && head_valid && (head_tag == req_tag);
        miss        = cpu_codemem_req && !hit;
        pop_fifo    = hit && !fifo_empty;
        bypass_take = hit && fifo_empty;
        push        = inflight_valid_q && !miss && !bypass_take;

        level = {1'b0, count_q} + {{CW{1'b0}}, inflight_valid_q} - {{CW{1'b0}}, hit};
        issue = (state_q == STREAM) && !miss && (level < (CW+1)'(DEPTH));

        if (miss) begin
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            count_d          = '0;
            inflight_valid_d = 1'b1;
            inflight_tag_d   = req_tag;
            next_addr_d      = req_tag + 1'b1;
            state_d          = STREAM;
            mem_en           = 1'b1;
            mem_addr         = req_tag;
        end else begin
            if (push) begin
                fifo_tag_d[wr_ptr_q]  = inflight_tag_q;
                fifo_data_d[wr_ptr_q] = mem_buf_rdata;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop_fifo) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop_fifo);
            if (issue) begin
                inflight_valid_d = 1'b1;
                inflight_tag_d   = next_addr_q;
                next_addr_d      = next_addr_q + 1'b1;
                mem_en           = 1'b1;
                mem_addr         = next_addr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            inflight_valid_q <= 1'b0;
            inflight_tag_q   <= '0;
            next_addr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_tag_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_tag_q   <= inflight_tag_d;
            next_addr_q      <= next_addr_d;
            fifo_tag_q       <= fifo_tag_d;
            fifo_data_q      <= fifo_data_d;
        end
    end

    assign codemem_cpu_ack   = hit;
    assign codemem_cpu_rdata = hit ? head_data : '0;
    assign buf_mem_en        = mem_en;
    assign buf_mem_addr      = mem_addr;
    assign dbg_state         = (state_q == STREAM);

    // The issue rule reserves a slot for every outstanding read, so this never fires.
    assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == CW'(DEPTH))))
        else $error("fetch buffer: returning word with FIFO full");

`ifdef NANORV32_FETCH_BUF_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (miss && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
